fp_issue_ctrl: RTL and testbench

FP_ISSUE_CTRL -- requirements
Module: fp_issue_ctrl

---
 rtl/fp_issue_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_fp_issue_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl: issue/decode controller for the FP pipe.
// Decodes FP-op / FP-load / FP-store instructions into a registered control
// bundle. Single-cycle ops retire one cycle after accept. FDIV/FSQRT hold the
// controller busy and retire exactly DIV_LAT/SQRT_LAT cycles after accept.
// Ports:
//   clk, rst                  clock, async active-high reset
//   in_valid/in_ready         instruction handshake (opcode, func5, rd)
//   flush                     synchronous abort of accepted/in-flight work
//   out_valid                 1-cycle retire pulse with the control bundle
//   ir_mux..wb_int_en, out_rd registered control bundle (zero when idle)
//   illegal                   retiring instruction had an undecoded opcode
//   busy                      multi-cycle operation in flight
module fp_issue_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned DIV_LAT    = 8,
  parameter int unsigned SQRT_LAT   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            opcode,
  input  logic [4:0]            func5,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [1:0]            ir_mux,
  output logic                  mwr,
  output logic                  b_mux,
  output logic                  werf,
  output logic                  move_en,
  output logic                  move_dir,
  output logic                  cvt_en,
  output logic                  is_unsigned,
  output logic                  wb_sel,
  output logic                  wb_fp_en,
  output logic                  wb_int_en,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  illegal,
  output logic                  busy
);

  localparam int unsigned MAX_LAT = (DIV_LAT > SQRT_LAT) ? DIV_LAT : SQRT_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT);

  localparam logic [6:0] OP_FP    = 7'b1010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000111;
  localparam logic [6:0] OP_STORE = 7'b0100111;

  localparam logic [4:0] F5_MV_X  = 5'b11101;
  localparam logic [4:0] F5_MV_F  = 5'b11110;
  localparam logic [4:0] F5_CVT_F = 5'b11100;
  localparam logic [4:0] F5_CVT_U = 5'b11111;
  localparam logic [4:0] F5_DIV   = 5'b00011;
  localparam logic [4:0] F5_SQRT  = 5'b01011;

  typedef enum logic {IDLE, MULTI} state_t;

  typedef struct packed {
    logic [1:0] ir_mux;
    logic       mwr;
    logic       b_mux;
    logic       werf;
    logic       move_en;
    logic       move_dir;
    logic       cvt_en;
    logic       is_unsigned;
    logic       wb_sel;
    logic       wb_fp_en;
    logic       wb_int_en;
    logic       illegal;
  } ctrl_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  ctrl_t                   ctrl_q, ctrl_d;
  ctrl_t                   hold_q, hold_d;
  logic [REG_ADDR_W-1:0]   hold_rd_q, hold_rd_d;
  logic [REG_ADDR_W-1:0]   out_rd_d;
  logic                    out_valid_d;
  logic                    busy_d;

  ctrl_t                   dec;
  logic                    dec_multi;
  logic [CNT_W-1:0]        dec_cnt;
  logic                    accept;

  // Instruction decode into the control bundle
  always_comb begin
    dec       = '0;
    dec_multi = 1'b0;
    dec_cnt   = '0;
    case (opcode)
      OP_FP: begin
        dec.ir_mux = 2'b10;
        dec.werf   = 1'b1;
        case (func5)
          F5_MV_X: begin
            dec.move_en   = 1'b1;
            dec.move_dir  = 1'b1;
            dec.wb_int_en = 1'b1;
          end
          F5_MV_F: begin
            dec.move_en  = 1'b1;
            dec.wb_fp_en = 1'b1;
          end
          F5_CVT_F: begin
            dec.cvt_en   = 1'b1;
            dec.wb_fp_en = 1'b1;
          end
          F5_CVT_U: begin
            dec.cvt_en      = 1'b1;
            dec.is_unsigned = 1'b1;
            dec.wb_int_en   = 1'b1;
          end
          F5_DIV: begin
            dec.wb_fp_en = 1'b1;
            dec_multi    = 1'b1;
            dec_cnt      = CNT_W'(DIV_LAT - 1);
          end
          F5_SQRT: begin
            dec.wb_fp_en = 1'b1;
            dec_multi    = 1'b1;
            dec_cnt      = CNT_W'(SQRT_LAT - 1);
          end
          default: dec.wb_fp_en = 1'b1;
        endcase
      end
      OP_LOAD: begin
        dec.ir_mux   = 2'b01;
        dec.mwr      = 1'b1;
        dec.b_mux    = 1'b1;
        dec.werf     = 1'b1;
        dec.wb_sel   = 1'b1;
        dec.wb_fp_en = 1'b1;
      end
      OP_STORE: begin
        dec.ir_mux = 2'b00;
        dec.mwr    = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // in_ready is a pure decode of the state register; IDLE also covers the
  // retire cycle of a multi-cycle op, so a new accept can overlap it.
  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready && !flush;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_rd_d   = hold_rd_q;
    out_valid_d = 1'b0;
    ctrl_d      = '0;
    out_rd_d    = '0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (dec_multi) begin
              hold_d    = dec;
              hold_rd_d = rd;
              cnt_d     = dec_cnt;
              state_d   = MULTI;
            end else begin
              out_valid_d = 1'b1;
              ctrl_d      = dec;
              out_rd_d    = rd;
            end
          end
        end
        MULTI: begin
          if (cnt_q == '0) begin
            out_valid_d = 1'b1;
            ctrl_d      = hold_q;
            out_rd_d    = hold_rd_q;
            state_d     = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d == MULTI);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      hold_rd_q <= '0;
      out_valid <= 1'b0;
      ctrl_q    <= '0;
      out_rd    <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      hold_rd_q <= hold_rd_d;
      out_valid <= out_valid_d;
      ctrl_q    <= ctrl_d;
      out_rd    <= out_rd_d;
      busy      <= busy_d;
    end
  end

  assign ir_mux      = ctrl_q.ir_mux;
  assign mwr         = ctrl_q.mwr;
  assign b_mux       = ctrl_q.b_mux;
  assign werf        = ctrl_q.werf;
  assign move_en     = ctrl_q.move_en;
  assign move_dir    = ctrl_q.move_dir;
  assign cvt_en      = ctrl_q.cvt_en;
  assign is_unsigned = ctrl_q.is_unsigned;
  assign wb_sel      = ctrl_q.wb_sel;
  assign wb_fp_en    = ctrl_q.wb_fp_en;
  assign wb_int_en   = ctrl_q.wb_int_en;
  assign illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// tb_fp_issue_ctrl: scoreboard bench for fp_issue_ctrl (default parameters).
// Expected bundles are pushed when an instruction is driven and popped by a
// negedge monitor whenever out_valid pulses; scenario tasks check timing.
module tb_fp_issue_ctrl;

  localparam int unsigned RW   = 5;
  localparam int unsigned DLAT = 8;
  localparam int unsigned SLAT = 12;

  localparam logic [6:0] OP_FP    = 7'b1010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000111;
  localparam logic [6:0] OP_STORE = 7'b0100111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  typedef struct {
    logic [12:0]   v;
    logic [RW-1:0] rd;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    opcode;
  logic [4:0]    func5;
  logic [RW-1:0] rd;
  logic          flush;
  logic          out_valid;
  logic [1:0]    ir_mux;
  logic          mwr, b_mux, werf, move_en, move_dir, cvt_en, is_unsigned;
  logic          wb_sel, wb_fp_en, wb_int_en;
  logic [RW-1:0] out_rd;
  logic          illegal;
  logic          busy;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  fp_issue_ctrl #(.REG_ADDR_W(RW), .DIV_LAT(DLAT), .SQRT_LAT(SLAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func5(func5), .rd(rd), .flush(flush),
    .out_valid(out_valid), .ir_mux(ir_mux), .mwr(mwr), .b_mux(b_mux),
    .werf(werf), .move_en(move_en), .move_dir(move_dir), .cvt_en(cvt_en),
    .is_unsigned(is_unsigned), .wb_sel(wb_sel), .wb_fp_en(wb_fp_en),
    .wb_int_en(wb_int_en), .out_rd(out_rd), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference decode: {ir_mux[1:0], mwr, b_mux, werf, move_en, move_dir,
  //                    cvt_en, is_unsigned, wb_sel, wb_fp_en, wb_int_en, illegal}
  function automatic logic [12:0] exp_vec(input logic [6:0] op, input logic [4:0] f5);
    logic [1:0] im;
    logic m, b, w, mv, md, cv, un, ws, wf, wi, il;
    {im, m, b, w, mv, md, cv, un, ws, wf, wi, il} = '0;
    if (op == OP_FP) begin
      im = 2'b10; w = 1'b1;
      if (f5 == 5'b11101)      begin mv = 1'b1; md = 1'b1; wi = 1'b1; end
      else if (f5 == 5'b11110) begin mv = 1'b1; wf = 1'b1; end
      else if (f5 == 5'b11100) begin cv = 1'b1; wf = 1'b1; end
      else if (f5 == 5'b11111) begin cv = 1'b1; un = 1'b1; wi = 1'b1; end
      else                          wf = 1'b1;
    end else if (op == OP_LOAD) begin
      im = 2'b01; m = 1'b1; b = 1'b1; w = 1'b1; ws = 1'b1; wf = 1'b1;
    end else if (op == OP_STORE) begin
      m = 1'b1;
    end else begin
      il = 1'b1;
    end
    return {im, m, b, w, mv, md, cv, un, ws, wf, wi, il};
  endfunction

  // Scoreboard monitor: retire content, and all-zero bundle when not valid
  always @(negedge clk) begin
    logic [12:0] obs;
    exp_t e;
    obs = {ir_mux, mwr, b_mux, werf, move_en, move_dir, cvt_en, is_unsigned,
           wb_sel, wb_fp_en, wb_int_en, illegal};
    total++;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_retire t=%0t bundle=%b rd=%0d expected no retire", $time, obs, out_rd);
      end else begin
        e = sb.pop_front();
        if (obs !== e.v || out_rd !== e.rd) begin
          bad++;
          $display("FAIL retire_bundle t=%0t got bundle=%b rd=%0d expected bundle=%b rd=%0d",
                   $time, obs, out_rd, e.v, e.rd);
        end
      end
    end else if (out_valid === 1'b0) begin
      if (obs !== 13'd0 || out_rd !== '0) begin
        bad++;
        $display("FAIL idle_zero t=%0t got bundle=%b rd=%0d expected all zero", $time, obs, out_rd);
      end
    end else begin
      bad++;
      $display("FAIL out_valid_known t=%0t got %b expected 0 or 1", $time, out_valid);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] f5, input logic [RW-1:0] r);
    in_valid = 1'b1;
    opcode   = op;
    func5    = f5;
    rd       = r;
  endtask

  task automatic push(input logic [6:0] op, input logic [4:0] f5, input logic [RW-1:0] r);
    exp_t e;
    e.v  = exp_vec(op, f5);
    e.rd = r;
    sb.push_back(e);
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    opcode   = '0;
    func5    = '0;
    rd       = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    idle_in();
    repeat (3) step();
    total++;
    if ({out_valid, busy, illegal, ir_mux, out_rd} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b busy=%b ill=%b mux=%b rd=%0d expected all 0",
               out_valid, busy, illegal, ir_mux, out_rd);
    end
    rst = 1'b0;
    step();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got %b expected 1", in_ready);
    end
  endtask

  task automatic test_move();
    drive(OP_FP, 5'b11101, 5'd7);
    push(OP_FP, 5'b11101, 5'd7);
    step();
    idle_in();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL move_latency got out_valid=%b expected 1", out_valid);
    end
    step();
  endtask

  // Every single-cycle decode row, issued on consecutive cycles
  task automatic test_back_to_back();
    logic [6:0] ops [8];
    logic [4:0] fs  [8];
    ops = '{OP_LOAD, OP_STORE, OP_FP, OP_FP, OP_FP, OP_FP, OP_BAD, OP_FP};
    fs  = '{5'b00000, 5'b00101, 5'b11110, 5'b11100, 5'b11111, 5'b00000, 5'b10101, 5'b11101};
    for (int i = 0; i < 8; i++) begin
      drive(ops[i], fs[i], RW'(i + 3));
      push(ops[i], fs[i], RW'(i + 3));
      step();
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_retire idx=%0d got out_valid=%b in_ready=%b expected 1 1", i, out_valid, in_ready);
      end
    end
    idle_in();
    step();
  endtask

  task automatic test_multi(input logic [4:0] f5, input int lat, input logic [RW-1:0] r);
    drive(OP_FP, f5, r);
    push(OP_FP, f5, r);
    step();
    idle_in();
    for (int k = 1; k < lat; k++) begin
      step();
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL multi_busy f5=%b k=%0d got v=%b busy=%b rdy=%b expected 0 1 0",
                 f5, k, out_valid, busy, in_ready);
      end
    end
    step();
    total++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL multi_retire f5=%b got v=%b busy=%b rdy=%b expected 1 0 1",
               f5, out_valid, busy, in_ready);
    end
    // accept overlapping the multi-cycle retire
    drive(OP_STORE, 5'd0, 5'd17);
    push(OP_STORE, 5'd0, 5'd17);
    step();
    idle_in();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL multi_overlap got out_valid=%b expected 1", out_valid);
    end
    step();
  endtask

  task automatic test_flush();
    int seen;
    drive(OP_FP, 5'b01011, 5'd4);
    step();
    idle_in();
    repeat (4) step();
    flush = 1'b1;
    drive(OP_LOAD, 5'd0, 5'd6);
    step();
    flush = 1'b0;
    idle_in();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_abort got v=%b busy=%b rdy=%b expected 0 0 1", out_valid, busy, in_ready);
    end
    seen = 0;
    repeat (SLAT + 2) begin
      step();
      if (out_valid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL flush_no_retire got %0d retires expected 0", seen);
    end
    // flush in IDLE suppresses the accept in the same cycle
    flush = 1'b1;
    drive(OP_LOAD, 5'd0, 5'd8);
    step();
    flush = 1'b0;
    idle_in();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle_accept got out_valid=%b expected 0", out_valid);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int seen;
    drive(OP_FP, 5'b00011, 5'd9);
    step();
    idle_in();
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_rd !== '0) begin
      bad++;
      $display("FAIL async_reset got v=%b busy=%b rdy=%b rd=%0d expected 0 0 1 0",
               out_valid, busy, in_ready, out_rd);
    end
    step();
    rst = 1'b0;
    seen = 0;
    repeat (DLAT + 2) begin
      step();
      if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_abandon got %0d active cycles expected 0", seen);
    end
    drive(OP_FP, 5'b00000, 5'd21);
    push(OP_FP, 5'b00000, 5'd21);
    step();
    idle_in();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_retire got out_valid=%b expected 1", out_valid);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_move();
    test_back_to_back();
    test_multi(5'b00011, DLAT, 5'd9);
    test_multi(5'b01011, SLAT, 5'd12);
    test_flush();
    test_reset_mid();
    repeat (2) step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
